// File: rtl/touch_scan_sched.sv
// Touch-panel conversion scheduler: debounces the pen, paces engine start requests,
// averages a burst of x/y samples and hands one coordinate per burst to the consumer.
`timescale 1ns/1ps
module touch_scan_sched #(
   parameter int SAMPLE_PERIOD = 50_000_000,
   parameter int DEBOUNCE      = 1_000_000,
   parameter int NAVG_LOG2     = 2,
   parameter int TIMEOUT       = 1_400_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_enable,
   input  logic       i_pen_irq_n,
   output logic       o_eng_start_n,
   input  logic       i_eng_done,
   input  logic [7:0] i_eng_x,
   input  logic [7:0] i_eng_y,
   output logic [7:0] o_xy_x,
   output logic [7:0] o_xy_y,
   output logic       o_xy_valid,
   input  logic       i_xy_ready,
   output logic       o_pen_down,
   output logic       o_timeout_err,
   input  logic       i_err_clr
);

   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int TW = $clog2(TIMEOUT);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int AW = 8 + NAVG_LOG2;
   localparam int NW = NAVG_LOG2 + 1;
   localparam logic [NW-1:0] NSAMP = NW'(1 << NAVG_LOG2);

   // One-hot so the engine start and valid pins each come straight off one flop.
   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_WAIT_PER  = 6'b000010,
      S_REQ       = 6'b000100,
      S_WAIT_DONE = 6'b001000,
      S_ACC       = 6'b010000,
      S_OUT       = 6'b100000
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic            r_pen_s1, r_pen_s2, r_pen_last, r_pen_down;
   logic            r_done_s1, r_done_s2, r_done_s3;
   logic [DW-1:0]   r_db_cnt;
   logic [PW-1:0]   r_per_cnt;
   logic [TW-1:0]   r_to_cnt;
   logic [7:0]      r_cap_x, r_cap_y;
   logic [AW-1:0]   r_sum_x, r_sum_y;
   logic [NW-1:0]   r_n;
   logic [7:0]      r_xy_x, r_xy_y;
   logic            r_timeout_err;

   logic            w_done_edge, w_per_hit, w_to_hit, w_last_sample, w_abort, w_timeout;
   logic [AW-1:0]   w_sum_x, w_sum_y;

   assign w_done_edge   = r_done_s2 & ~r_done_s3;
   assign w_per_hit     = (r_per_cnt == PW'(SAMPLE_PERIOD - 1));
   assign w_to_hit      = (r_to_cnt == TW'(TIMEOUT - 1));
   assign w_last_sample = ((r_n + NW'(1)) == NSAMP);
   assign w_sum_x       = r_sum_x + AW'(r_cap_x);
   assign w_sum_y       = r_sum_y + AW'(r_cap_y);
   assign w_timeout     = (r_state == S_WAIT_DONE) && !w_done_edge && w_to_hit;
   assign w_abort       = ((r_state == S_WAIT_PER) && (w_next_state == S_IDLE)) || w_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pen_s1   <= 1'b1;
         r_pen_s2   <= 1'b1;
         r_pen_last <= 1'b1;
         r_pen_down <= 1'b0;
         r_db_cnt   <= '0;
         r_done_s1  <= 1'b0;
         r_done_s2  <= 1'b0;
         r_done_s3  <= 1'b0;
      end else begin
         r_pen_s1  <= i_pen_irq_n;
         r_pen_s2  <= r_pen_s1;
         r_done_s1 <= i_eng_done;
         r_done_s2 <= r_done_s1;
         r_done_s3 <= r_done_s2;
         if (r_pen_s2 != r_pen_last) begin
            r_pen_last <= r_pen_s2;
            r_db_cnt   <= '0;
         end else if (r_db_cnt != DW'(DEBOUNCE)) begin
            r_db_cnt <= r_db_cnt + DW'(1);
            if (r_db_cnt == DW'(DEBOUNCE - 1))
               r_pen_down <= ~r_pen_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:      if (r_pen_down && i_enable) w_next_state = S_WAIT_PER;
         S_WAIT_PER:  if (!r_pen_down || !i_enable) w_next_state = S_IDLE;
                      else if (w_per_hit)           w_next_state = S_REQ;
         S_REQ:       w_next_state = S_WAIT_DONE;
         S_WAIT_DONE: if (w_done_edge)   w_next_state = S_ACC;
                      else if (w_to_hit) w_next_state = S_IDLE;
         S_ACC:       w_next_state = w_last_sample ? S_OUT : S_WAIT_PER;
         S_OUT:       if (i_xy_ready) w_next_state = S_WAIT_PER;
         default:     w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_eng_start_n = ~r_state[3];
      o_xy_valid    = r_state[5];
      o_xy_x        = r_xy_x;
      o_xy_y        = r_xy_y;
      o_pen_down    = r_pen_down;
      o_timeout_err = r_timeout_err;
   end

   // Period counter is loaded in IDLE so the first request follows the press at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_per_cnt     <= '0;
         r_to_cnt      <= '0;
         r_cap_x       <= '0;
         r_cap_y       <= '0;
         r_sum_x       <= '0;
         r_sum_y       <= '0;
         r_n           <= '0;
         r_xy_x        <= '0;
         r_xy_y        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE)
            r_per_cnt <= PW'(SAMPLE_PERIOD - 1);
         else
            r_per_cnt <= w_per_hit ? '0 : r_per_cnt + PW'(1);

         if (r_state == S_REQ)
            r_to_cnt <= '0;
         else if (r_state == S_WAIT_DONE)
            r_to_cnt <= r_to_cnt + TW'(1);

         if ((r_state == S_WAIT_DONE) && w_done_edge) begin
            r_cap_x <= i_eng_x;
            r_cap_y <= i_eng_y;
         end

         if (w_abort) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_n     <= '0;
         end else if (r_state == S_ACC) begin
            if (w_last_sample) begin
               r_xy_x  <= w_sum_x[AW-1:NAVG_LOG2];
               r_xy_y  <= w_sum_y[AW-1:NAVG_LOG2];
               r_sum_x <= '0;
               r_sum_y <= '0;
               r_n     <= '0;
            end else begin
               r_sum_x <= w_sum_x;
               r_sum_y <= w_sum_y;
               r_n     <= r_n + NW'(1);
            end
         end

         if (i_err_clr)
            r_timeout_err <= 1'b0;
         else if (w_timeout)
            r_timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_touch_scan_sched.sv
// Bench for touch_scan_sched: behavioural engine and consumer, with a sample scoreboard
// that averages each delivered burst of four conversions.
`timescale 1ns/1ps
module tb_touch_scan_sched;

   localparam int SP = 10;
   localparam int DB = 4;
   localparam int NL = 2;
   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_enable;
   logic       i_pen_irq_n;
   logic       o_eng_start_n;
   logic       i_eng_done;
   logic [7:0] i_eng_x, i_eng_y;
   logic [7:0] o_xy_x, o_xy_y;
   logic       o_xy_valid;
   logic       i_xy_ready;
   logic       o_pen_down;
   logic       o_timeout_err;
   logic       i_err_clr;

   always #5 clk = ~clk;

   touch_scan_sched #(
      .SAMPLE_PERIOD(SP), .DEBOUNCE(DB), .NAVG_LOG2(NL), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pen_irq_n(i_pen_irq_n),
      .o_eng_start_n(o_eng_start_n), .i_eng_done(i_eng_done),
      .i_eng_x(i_eng_x), .i_eng_y(i_eng_y), .o_xy_x(o_xy_x), .o_xy_y(o_xy_y),
      .o_xy_valid(o_xy_valid), .i_xy_ready(i_xy_ready), .o_pen_down(o_pen_down),
      .o_timeout_err(o_timeout_err), .i_err_clr(i_err_clr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Scoreboard: samples handed out by the engine in the current burst.
   int fx_q[$], fy_q[$];
   int mx_q[$], my_q[$];
   bit eng_mute = 1'b0;
   int rdy_mode = 0;
   int n_starts = 0, n_results = 0, n_valid_rise = 0;

   task automatic clear_model();
      mx_q.delete();
      my_q.delete();
   endtask

   // Engine: random latency, done held 3 cycles, data stable throughout.
   initial begin
      int x, y;
      i_eng_done = 1'b0;
      i_eng_x    = '0;
      i_eng_y    = '0;
      forever begin
         @(negedge clk);
         if (rst_n && !o_eng_start_n) begin
            if (!eng_mute) begin
               repeat ($urandom_range(1, 4)) @(negedge clk);
               if (fx_q.size() > 0) begin
                  x = fx_q.pop_front();
                  y = fy_q.pop_front();
               end else begin
                  x = $urandom_range(0, 255);
                  y = $urandom_range(0, 255);
               end
               i_eng_x    = 8'(x);
               i_eng_y    = 8'(y);
               i_eng_done = 1'b1;
               mx_q.push_back(x);
               my_q.push_back(y);
               repeat (3) @(negedge clk);
               i_eng_done = 1'b0;
            end
            while (!o_eng_start_n) @(negedge clk);
         end
      end
   end

   initial begin
      i_xy_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       i_xy_ready = 1'b0;
            1:       i_xy_ready = 1'b1;
            default: i_xy_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor: every accepted result must equal the truncated mean of its burst.
   initial begin
      logic prev_start = 1'b1;
      logic prev_valid = 1'b0;
      int   sx, sy;
      forever begin
         @(negedge clk);
         #1;
         if (prev_start && !o_eng_start_n) n_starts++;
         if (!prev_valid && o_xy_valid) n_valid_rise++;
         prev_start = o_eng_start_n;
         prev_valid = o_xy_valid;
         if (rst_n && o_xy_valid && i_xy_ready) begin
            check_val("burst_len", mx_q.size(), 4);
            sx = 0;
            sy = 0;
            for (int i = 0; i < 4; i++) begin
               if (mx_q.size() > 0) begin
                  sx += mx_q.pop_front();
                  sy += my_q.pop_front();
               end
            end
            check_val("avg_x", o_xy_x, sx >> NL);
            check_val("avg_y", o_xy_y, sy >> NL);
            $display("result %0d: x=%0d y=%0d", n_results, o_xy_x, o_xy_y);
            n_results++;
         end
      end
   end

   task automatic wait_results(input int target, input int budget, input string tag);
      int t = 0;
      while (n_results < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_val(tag, (n_results >= target), 1);
   endtask

   task automatic wait_start_fall(input int budget, input string tag);
      int t = 0;
      while (!o_eng_start_n && t < budget) begin
         @(negedge clk);
         t++;
      end
      while (o_eng_start_n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_val(tag, o_eng_start_n, 0);
   endtask

   initial begin
      int   t, low_cnt, base_r, base_v, st;
      logic [7:0] hx, hy;
      bit   stable;

      rst_n       = 1'b0;
      i_enable    = 1'b0;
      i_pen_irq_n = 1'b1;
      i_err_clr   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_start_n", o_eng_start_n, 1);
      check_val("rst_valid", o_xy_valid, 0);
      check_val("rst_xy_x", o_xy_x, 0);
      check_val("rst_xy_y", o_xy_y, 0);
      check_val("rst_pen_down", o_pen_down, 0);
      check_val("rst_timeout_err", o_timeout_err, 0);
      rst_n    = 1'b1;
      i_enable = 1'b1;
      repeat (20) @(negedge clk);

      // Short pen glitch is rejected by the debouncer.
      i_pen_irq_n = 1'b0;
      repeat (3) @(negedge clk);
      i_pen_irq_n = 1'b1;
      repeat (30) @(negedge clk);
      check_val("glitch_pen_down", o_pen_down, 0);
      check_val("glitch_starts", n_starts, 0);

      // Directed burst.
      fx_q = '{10, 12, 14, 16};
      fy_q = '{200, 201, 202, 203};
      i_pen_irq_n = 1'b0;
      t = 0;
      while (!o_xy_valid && t < 400) begin
         @(negedge clk);
         t++;
      end
      check_val("first_valid", o_xy_valid, 1);
      check_val("first_x", o_xy_x, 13);
      check_val("first_y", o_xy_y, 201);
      check_val("first_pen_down", o_pen_down, 1);
      rdy_mode = 1;
      wait_results(1, 50, "first_handshake");

      // Random data with a randomly stalling consumer.
      rdy_mode = 2;
      wait_results(7, 4000, "random_bursts");

      // Consumer stall: result held, no new requests.
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      t = 0;
      while (!o_xy_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_val("stall_valid", o_xy_valid, 1);
      hx     = o_xy_x;
      hy     = o_xy_y;
      st     = n_starts;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (!o_xy_valid || o_xy_x != hx || o_xy_y != hy) stable = 1'b0;
      end
      check_val("stall_stable", stable, 1);
      check_val("stall_no_start", n_starts, st);
      rdy_mode = 1;
      wait_results(n_results + 1, 50, "stall_release");

      // Pen released mid-burst: no result, next press starts fresh.
      i_pen_irq_n = 1'b1;
      repeat (60) @(negedge clk);
      check_val("release_pen_down", o_pen_down, 0);
      clear_model();
      base_r = n_results;
      base_v = n_valid_rise;
      i_pen_irq_n = 1'b0;
      t = 0;
      while (mx_q.size() < 2 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_val("partial_two_samples", (mx_q.size() >= 2), 1);
      i_pen_irq_n = 1'b1;
      repeat (100) @(negedge clk);
      check_val("partial_no_valid", n_valid_rise, base_v);
      check_val("partial_pen_down", o_pen_down, 0);
      clear_model();
      i_pen_irq_n = 1'b0;
      wait_results(base_r + 1, 600, "fresh_burst");

      // Engine never answers.
      eng_mute = 1'b1;
      wait_start_fall(300, "timeout_start");
      low_cnt = 1;
      t = 0;
      while (t < 300) begin
         @(negedge clk);
         t++;
         if (o_eng_start_n) break;
         low_cnt++;
      end
      check_val("timeout_low_cycles", low_cnt, TO);
      check_val("timeout_err_set", o_timeout_err, 1);
      i_enable = 1'b0;
      repeat (250) @(negedge clk);
      check_val("timeout_err_sticky", o_timeout_err, 1);
      st = n_starts;
      i_err_clr = 1'b1;
      @(negedge clk);
      i_err_clr = 1'b0;
      check_val("err_clr", o_timeout_err, 0);
      repeat (30) @(negedge clk);
      check_val("disabled_start_n", o_eng_start_n, 1);
      check_val("disabled_no_start", n_starts, st);
      clear_model();

      // Asynchronous reset while a conversion is outstanding.
      i_enable = 1'b1;
      wait_start_fall(300, "reset_start");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("arst_start_n", o_eng_start_n, 1);
      check_val("arst_valid", o_xy_valid, 0);
      check_val("arst_pen_down", o_pen_down, 0);
      repeat (3) @(negedge clk);
      rst_n    = 1'b1;
      eng_mute = 1'b0;
      clear_model();
      wait_results(n_results + 1, 800, "post_reset_burst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
